// File: rtl/ascii_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ascii_pkg: character constants and FSM state for the collector.   |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
package ascii_pkg;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_9  = 8'h39;
  localparam logic [7:0] ASCII_UA = 8'h41;
  localparam logic [7:0] ASCII_UF = 8'h46;
  localparam logic [7:0] ASCII_LA = 8'h61;
  localparam logic [7:0] ASCII_LF = 8'h66;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_OUT     = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/ascii_hex_collector_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ascii_hex_collector_if: character input and result output streams.|
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
interface ascii_hex_collector_if #(
  parameter int DIGITS = 4
);
  logic [7:0]                       in_data;
  logic                             in_valid;
  logic                             in_ready;
  logic [4*DIGITS-1:0]              out_value;
  logic [$clog2(DIGITS+1)-1:0]      out_digits;
  logic                             out_valid;
  logic                             out_ready;
  logic                             err;

  // Collector side
  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_value, out_digits, out_valid, err
  );

  // Producer / consumer side
  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_value, out_digits, out_valid, err
  );
endinterface
`default_nettype wire

// File: rtl/ascii2nibble.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ascii2nibble: ASCII char to hex nibble / CR flag decoder.         |
// | Macro ASCII_HEX_LOWERCASE_EN also accepts 'a'..'f'. Rev 1.0       |
// +------------------------------------------------------------------+
module ascii2nibble
  import ascii_pkg::*;
(
  input  logic [7:0] in,
  output logic [3:0] nib,
  output logic       is_hex,
  output logic       is_cr
);

  always_comb begin
    nib    = 4'd0;
    is_hex = 1'b0;
    is_cr  = (in == ASCII_CR);
    if (in >= ASCII_0 && in <= ASCII_9) begin
      is_hex = 1'b1;
      nib    = 4'(in - ASCII_0);
    end else if (in >= ASCII_UA && in <= ASCII_UF) begin
      is_hex = 1'b1;
      nib    = 4'(in - 8'h37);
    end
`ifdef ASCII_HEX_LOWERCASE_EN
    else if (in >= ASCII_LA && in <= ASCII_LF) begin
      is_hex = 1'b1;
      nib    = 4'(in - 8'h57);
    end
`endif
  end

endmodule
`default_nettype wire

// File: rtl/ascii_hex_collector.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ascii_hex_collector: assembles MSB-first hex digits until CR.     |
// | Honours ASCII_HEX_LOWERCASE_EN (via ascii2nibble). Rev 1.0        |
// +------------------------------------------------------------------+
module ascii_hex_collector
  import ascii_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  ascii_hex_collector_if.slave    bus
);

  localparam int VW = 4 * DIGITS;
  localparam int CW = $clog2(DIGITS + 1);

  state_t          state;
  state_t          state_next;
  logic [VW-1:0]   acc;
  logic [CW-1:0]   cnt;
  logic [VW-1:0]   value_q;
  logic [CW-1:0]   digits_q;
  logic            ready_q;
  logic            err_q;
  logic            err_next;
  logic [3:0]      nib;
  logic            is_hex;
  logic            is_cr;
  logic            accept;
  logic            full;

  ascii2nibble u_dec (
    .in     (bus.in_data),
    .nib    (nib),
    .is_hex (is_hex),
    .is_cr  (is_cr)
  );

  assign accept = bus.in_valid && ready_q;
  assign full   = (cnt == CW'(DIGITS));

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    err_next   = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (is_hex)      state_next = S_COLLECT;
          else if (!is_cr) err_next   = 1'b1;
        end
      end
      S_COLLECT: begin
        if (accept) begin
          if (is_hex && !full) begin
            state_next = S_COLLECT;
          end else if (is_cr) begin
            state_next = S_OUT;
          end else begin
            state_next = S_IDLE;
            err_next   = 1'b1;
          end
        end
      end
      S_OUT: begin
        if (bus.out_ready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    bus.out_valid  = (state == S_OUT);
    bus.in_ready   = ready_q;
    bus.err        = err_q;
    bus.out_value  = value_q;
    bus.out_digits = digits_q;
  end

  // acc/cnt are cleared as soon as the result is captured, so S_OUT holds only value_q
  always_ff @(posedge clk) begin
    if (rst) begin
      acc      <= '0;
      cnt      <= '0;
      value_q  <= '0;
      digits_q <= '0;
      ready_q  <= 1'b1;
      err_q    <= 1'b0;
    end else begin
      ready_q <= (state_next != S_OUT);
      err_q   <= err_next;
      if (accept) begin
        case (state)
          S_IDLE: begin
            if (is_hex) begin
              acc <= VW'(nib);
              cnt <= CW'(1);
            end
          end
          S_COLLECT: begin
            if (is_hex && !full) begin
              acc <= (acc << 4) | VW'(nib);
              cnt <= cnt + CW'(1);
            end else begin
              if (is_cr) begin
                value_q  <= acc;
                digits_q <= cnt;
              end
              acc <= '0;
              cnt <= '0;
            end
          end
          default: begin
            acc <= '0;
            cnt <= '0;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ascii_hex_collector.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_ascii_hex_collector: directed + random stimulus vs queue model.|
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module tb_ascii_hex_collector;

  localparam int DIGITS = 4;
  localparam logic [7:0] CR = 8'h0D;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  ascii_hex_collector_if #(.DIGITS(DIGITS)) bus ();

  ascii_hex_collector #(.DIGITS(DIGITS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: digits entered so far, plus any pending result
  int   q[$];
  bit   m_has;
  int   m_val;
  int   m_dig;
  bit   m_err;
  bit   m_zero;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int hexval(input logic [7:0] c);
    if (c >= 8'h30 && c <= 8'h39) return int'(c) - 48;
    if (c >= 8'h41 && c <= 8'h46) return int'(c) - 65 + 10;
`ifdef ASCII_HEX_LOWERCASE_EN
    if (c >= 8'h61 && c <= 8'h66) return int'(c) - 97 + 10;
`endif
    return -1;
  endfunction

  task automatic cycle(input logic r, input logic v, input logic [7:0] d, input logic o);
    bit acc;
    bit nerr;
    int h;
    rst           = r;
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.out_ready = o;
    @(negedge clk);
    check("in_ready",  32'(bus.in_ready),  32'(!m_has));
    check("out_valid", 32'(bus.out_valid), 32'(m_has));
    check("err",       32'(bus.err),       32'(m_err));
    if (m_has || m_zero) begin
      check("out_value",  32'(bus.out_value),  m_has ? m_val : 0);
      check("out_digits", 32'(bus.out_digits), m_has ? m_dig : 0);
    end
    if (r) begin
      q.delete();
      m_has  = 0;
      m_err  = 0;
      m_zero = 1;
    end else begin
      acc  = v && !m_has;
      nerr = 0;
      if (m_has && o) m_has = 0;
      if (acc) begin
        h = hexval(d);
        if (d == CR) begin
          if (q.size() > 0) begin
            m_val = 0;
            foreach (q[i]) m_val = m_val * 16 + q[i];
            m_dig  = q.size();
            m_has  = 1;
            m_zero = 0;
            q.delete();
          end
        end else if (h < 0 || q.size() == DIGITS) begin
          nerr = 1;
          q.delete();
        end else begin
          q.push_back(h);
        end
      end
      m_err = nerr;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_str(input string s, input logic o);
    for (int i = 0; i < s.len(); i++) cycle(1'b0, 1'b1, s[i], o);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 8'h00, 1'b1);
  endtask

  function automatic logic [7:0] rand_char();
    int k;
    k = $urandom_range(0, 9);
    case (k)
      0, 1, 2: return 8'(8'h30 + $urandom_range(0, 9));
      3, 4:    return 8'(8'h41 + $urandom_range(0, 5));
      5, 6:    return CR;
      7:       return 8'(8'h61 + $urandom_range(0, 5));
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  initial begin
    total = 0;
    bad   = 0;
    q.delete();
    m_has = 0; m_val = 0; m_dig = 0; m_err = 0; m_zero = 1;
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    idle(2);
    send_str("1A3F", 1'b1); cycle(1'b0, 1'b1, CR, 1'b1); idle(2);

    cycle(1'b0, 1'b1, "7", 1'b0);
    cycle(1'b0, 1'b1, CR,  1'b0);
    repeat (5) cycle(1'b0, 1'b1, "B", 1'b0);
    cycle(1'b0, 1'b1, "B", 1'b1);
    cycle(1'b0, 1'b1, "B", 1'b1);
    cycle(1'b0, 1'b1, CR,  1'b1);
    idle(2);

    send_str("12345", 1'b1); send_str("9", 1'b1);
    cycle(1'b0, 1'b1, CR, 1'b1); idle(2);

    send_str("G", 1'b1); cycle(1'b0, 1'b1, CR, 1'b1); idle(2);
    send_str("ab", 1'b1); cycle(1'b0, 1'b1, CR, 1'b1); idle(2);
    send_str("GH", 1'b1); idle(1);

    send_str("55", 1'b1);
    cycle(1'b1, 1'b0, 8'h00, 1'b1);
    cycle(1'b0, 1'b1, CR, 1'b1); idle(2);

    send_str("42", 1'b0); cycle(1'b0, 1'b1, CR, 1'b0);
    cycle(1'b1, 1'b1, "3", 1'b0); idle(2);

    for (int n = 0; n < 3000; n++) begin
      cycle(($urandom_range(0, 99) == 0),
            ($urandom_range(0, 9) < 8),
            rand_char(),
            ($urandom_range(0, 9) < 6));
    end
    idle(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ascii_hex_collector.md
# ascii_hex_collector

Inverse of the keyboard path's nibble-to-ASCII converter. It consumes a stream of ASCII characters over a valid/ready handshake from the keyboard/UART decoder. It accumulates up to DIGITS hexadecimal digits MSB-first and, on Enter (CR), presents the assembled binary value with its digit count over a second valid/ready handshake. Invalid characters and over-long entries are reported on a one-cycle error pulse and the entry is discarded.

## Interface
- DIGITS, 4: maximum hex digits per entry; value width is 4*DIGITS.
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_data  in  8  ASCII character.
- in_valid  in  1  in_data valid.
- in_ready  out  1  collector can accept a character.
- out_value  out  4*DIGITS  assembled value, right-aligned, zero-extended.
- out_digits  out  $clog2(DIGITS+1)  number of digits entered (1..DIGITS).
- out_valid  out  1  out_value/out_digits valid.
- out_ready  in  1  consumer accepts result.
- err  out  1  one-cycle pulse: entry discarded.

## Operation
- Character accepted when in_valid && in_ready. Nibble decode: 0x30–0x39 → c−0x30; 0x41–0x46 → c−0x37; CR = 0x0D is the terminator; anything else is invalid.
- States:
  - S_IDLE: acc=0, cnt=0, in_ready=1.
  - S_COLLECT: 1..DIGITS digits held, in_ready=1.
  - S_OUT: result held, in_ready=0, out_valid=1.
- S_IDLE + hex digit: acc←nib, cnt←1, go to S_COLLECT.
- S_IDLE + CR: ignored (empty line), no err, stay in S_IDLE.
- S_IDLE + invalid char: err pulse, stay in S_IDLE.
- S_COLLECT + hex digit, cnt<DIGITS: acc←{acc[4*DIGITS-5:0], nib}, cnt←cnt+1.
- S_COLLECT + hex digit, cnt==DIGITS: overflow. Err pulse, clear acc/cnt, go to S_IDLE.
- S_COLLECT + CR: out_value←acc, out_digits←cnt, go to S_OUT.
- S_COLLECT + invalid char: err pulse, clear, go to S_IDLE.
- S_OUT: out_value/out_digits stable while out_valid && !out_ready. Handshake clears acc/cnt and goes to S_IDLE.
- in_data is ignored whenever in_valid=0 or in_ready=0. Input while in S_OUT is back-pressured, not dropped.

## Timing
- Reset values: in_ready=1, out_valid=0, out_value=0, out_digits=0, err=0, state S_IDLE.
- rst has priority over every event in the same cycle, including mid-entry and in S_OUT. The pending result is lost and out_valid drops the next cycle.
- out_valid rises the cycle after CR is accepted. Latency from CR to result is 1 cycle.
- in_ready is registered, derived from next state. It falls in the same cycle out_valid rises.
- After the output handshake in cycle N, in_ready=1 and out_valid=0 in cycle N+1. A character can be accepted in N+1, not N.
- err is registered. It is high for exactly the cycle after the offending character is accepted. A back-to-back invalid character gives a pulse each cycle.
- The collector accepts one character per cycle at full throughput in S_IDLE/S_COLLECT.

## Configuration
- ASCII_HEX_LOWERCASE_EN defined: 0x61–0x66 decode as c−0x57, equivalent to uppercase.
- Undefined: lowercase a–f are invalid and produce an err pulse and discard.

## Structure
- Shared package `ascii_pkg`:
  - constants ASCII_CR, ASCII_0, ASCII_9, ASCII_UA, ASCII_UF, ASCII_LA, ASCII_LF;
  - state typedef (S_IDLE, S_COLLECT, S_OUT).
- Sub-module `ascii2nibble`: combinational; in[7:0] → nib[3:0], is_hex, is_cr. The macro is applied inside it.
- Top: FSM, accumulator, counter, and output registers.

## Test plan
- Reset, then send '1','A','3','F',CR with out_ready=1 → out_valid one cycle, out_value=16'h1A3F, out_digits=3'd4, err never high.
- Send '7',CR with out_ready=0 for 5 cycles and in_valid held with 'B' → value 16'h0007 and digits 1 stable; in_ready=0 throughout; 'B' accepted the cycle after the handshake.
- Send '1','2','3','4','5' → err pulse after '5', state S_IDLE; then '9',CR → out_value=16'h0009.
- Send 'G' and CR alone → err pulse for 'G' only; no out_valid for bare CR.
- Send 'a','b',CR → with ASCII_HEX_LOWERCASE_EN, out_value=16'h00AB, digits 2; without it, err pulse after 'a' and after 'b', and no out_valid.
- Send '5','5', assert rst for one cycle, then CR → no out_valid, in_ready=1, all outputs zero after reset.
